// File: rtl/uart_transmitter_if.sv
// UART transmitter port bundle: data source, enable and baud tick in,
// serial line and busy flag out.
interface uart_transmitter_if;
  logic [7:0] Tx_DATA;
  logic       Tx_WR;
  logic       Tx_EN;
  logic       Tx_sample_ENABLE;
  logic       TxD;
  logic       Tx_BUSY;

  modport master (
    output Tx_DATA,
    output Tx_WR,
    output Tx_EN,
    output Tx_sample_ENABLE,
    input  TxD,
    input  Tx_BUSY
  );

  modport slave (
    input  Tx_DATA,
    input  Tx_WR,
    input  Tx_EN,
    input  Tx_sample_ENABLE,
    output TxD,
    output Tx_BUSY
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: 8E1 frames (start, D0..D7 LSB first, even parity, stop),
// each bit held for 16 ticks of the 16x baud sample enable.
module uart_transmitter (
  input  logic               clk,
  input  logic               reset,
  uart_transmitter_if.slave  tx
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        accept;
  logic        last_tick;

  assign accept    = tx.Tx_WR & tx.Tx_EN & ~busy_q;
  assign last_tick = tx.Tx_sample_ENABLE & (cnt_q == 4'd15);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    if (state_q == IDLE) begin
      // a tick coinciding with acceptance is deliberately not counted
      if (accept) begin
        state_d = START;
        cnt_d   = 4'd0;
        bit_d   = 3'd0;
        shreg_d = tx.Tx_DATA;
        par_d   = ^tx.Tx_DATA;
        txd_d   = 1'b0;
        busy_d  = 1'b1;
      end
    end else if (tx.Tx_sample_ENABLE) begin
      cnt_d = cnt_q + 4'd1;
      if (last_tick) begin
        unique case (state_q)
          START: begin
            state_d = DATA;
            bit_d   = 3'd0;
            txd_d   = shreg_q[0];
          end
          DATA: begin
            if (bit_q == 3'd7) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              bit_d   = bit_q + 3'd1;
              shreg_d = {1'b0, shreg_q[7:1]};
              txd_d   = shreg_q[1];
            end
          end
          PARITY: begin
            state_d = STOP;
            txd_d   = 1'b1;
          end
          STOP: begin
            state_d = IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end
          default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end
        endcase
      end
    end
  end

  assign tx.TxD     = txd_q;
  assign tx.Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: tick-count frame model checked every cycle,
// plus directed frames compared against hand-built literal bit sequences.
module tb_uart_transmitter;

  logic clk;
  logic reset;
  uart_transmitter_if ifc ();

  uart_transmitter dut (
    .clk   (clk),
    .reset (reset),
    .tx    (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model: a frame is 11 bits of 16 ticks; bit shown = ticks_seen/16
  logic        m_busy = 1'b0;
  int          m_k = 0;
  logic [10:0] m_bits = '1;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_k    <= 0;
    end else if (!m_busy) begin
      if (ifc.Tx_WR && ifc.Tx_EN) begin
        m_busy <= 1'b1;
        m_k    <= 0;
        m_bits <= {1'b1, ^ifc.Tx_DATA, ifc.Tx_DATA, 1'b0};
      end
    end else if (ifc.Tx_sample_ENABLE) begin
      m_k <= m_k + 1;
      if (m_k == 175) m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic m_txd;
    if (chk_en) begin
      m_txd = m_busy ? m_bits[m_k / 16] : 1'b1;
      checks++;
      if (ifc.TxD !== m_txd || ifc.Tx_BUSY !== m_busy) begin
        errors++;
        $display("FAIL cycle_model t=%0t TxD=%b busy=%b required TxD=%b busy=%b",
                 $time, ifc.TxD, ifc.Tx_BUSY, m_txd, m_busy);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // tick on every clk; samples each bit mid-way and counts busy cycles
  task automatic frame(input string name, input logic [7:0] data,
                       input logic [10:0] lit, input int inj_at,
                       input logic [7:0] inj_data, input int en_off_at,
                       input bit hold);
    logic [10:0] cap;
    int nbusy;
    cap   = '0;
    nbusy = 0;
    ifc.Tx_DATA          = data;
    ifc.Tx_WR            = 1'b1;
    ifc.Tx_EN            = 1'b1;
    ifc.Tx_sample_ENABLE = 1'b1;
    @(negedge clk);
    if (!hold) ifc.Tx_WR = 1'b0;
    nbusy += int'(ifc.Tx_BUSY);
    check({name, "_model_bits"}, 32'(m_bits), 32'(lit));
    for (int j = 0; j < 176; j++) begin
      if (j == inj_at) begin
        ifc.Tx_DATA = inj_data;
        ifc.Tx_WR   = 1'b1;
      end else if (!hold) begin
        ifc.Tx_WR = 1'b0;
      end
      if (j == en_off_at) ifc.Tx_EN = 1'b0;
      @(negedge clk);
      if (j % 16 == 7) cap[j / 16] = ifc.TxD;
      nbusy += int'(ifc.Tx_BUSY);
    end
    check({name, "_bits"}, 32'(cap), 32'(lit));
    check({name, "_busy_cycles"}, 32'(nbusy), 32'd176);
    check({name, "_end_txd"}, 32'(ifc.TxD), 32'd1);
    check({name, "_end_busy"}, 32'(ifc.Tx_BUSY), 32'd0);
  endtask

  initial begin
    reset                = 1'b1;
    ifc.Tx_DATA          = 8'h00;
    ifc.Tx_WR            = 1'b0;
    ifc.Tx_EN            = 1'b0;
    ifc.Tx_sample_ENABLE = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_txd", 32'(ifc.TxD), 32'd1);
    check("reset_busy", 32'(ifc.Tx_BUSY), 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    frame("aa", 8'hAA, 11'b10101010100, -1, 8'h00, -1, 1'b0);
    frame("h89", 8'h89, 11'b11100010010, -1, 8'h00, -1, 1'b0);
    frame("h55_ignore_cc", 8'h55, 11'b10010101010, 40, 8'hCC, -1, 1'b0);

    ifc.Tx_EN   = 1'b0;
    ifc.Tx_WR   = 1'b1;
    ifc.Tx_DATA = 8'hFF;
    for (int j = 0; j < 40; j++) begin
      ifc.Tx_sample_ENABLE = ($urandom % 2) == 0;
      @(negedge clk);
    end
    check("en_off_txd", 32'(ifc.TxD), 32'd1);
    check("en_off_busy", 32'(ifc.Tx_BUSY), 32'd0);
    ifc.Tx_WR = 1'b0;
    frame("h5a_en_drop", 8'h5A, 11'b10010110100, -1, 8'h00, 20, 1'b0);
    ifc.Tx_WR   = 1'b1;
    ifc.Tx_DATA = 8'h33;
    @(negedge clk);
    ifc.Tx_WR = 1'b0;
    @(negedge clk);
    check("after_en_drop_busy", 32'(ifc.Tx_BUSY), 32'd0);

    ifc.Tx_EN   = 1'b1;
    ifc.Tx_WR   = 1'b1;
    ifc.Tx_DATA = 8'h3C;
    @(negedge clk);
    ifc.Tx_WR = 1'b0;
    repeat (89) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midframe_reset_txd", 32'(ifc.TxD), 32'd1);
    check("midframe_reset_busy", 32'(ifc.Tx_BUSY), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    frame("h01", 8'h01, 11'b11000000010, -1, 8'h00, -1, 1'b0);

    frame("hold1", 8'hAA, 11'b10101010100, -1, 8'h00, -1, 1'b1);
    frame("hold2", 8'hAA, 11'b10101010100, -1, 8'h00, -1, 1'b1);
    ifc.Tx_WR = 1'b0;
    @(negedge clk);

    for (int c = 0; c < 30000; c++) begin
      ifc.Tx_sample_ENABLE = ($urandom % 4) == 0;
      ifc.Tx_WR            = ($urandom % 8) == 0;
      ifc.Tx_EN            = ($urandom % 10) != 0;
      ifc.Tx_DATA          = 8'($urandom);
      reset                = ($urandom % 4000) == 0;
      @(negedge clk);
    end
    reset     = 1'b0;
    ifc.Tx_WR = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
